// File: rtl/hmmm_pkg.sv
// HMMM multicycle core shared definitions.
// Opcode and FSM state enums plus instruction field extractors.
package hmmm_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_HALT   = 4'h1,
        OP_SETN   = 4'h2,
        OP_LOADN  = 4'h3,
        OP_STOREN = 4'h4,
        OP_LOADR  = 4'h5,
        OP_STORER = 4'h6,
        OP_ADD    = 4'h7,
        OP_SUB    = 4'h8,
        OP_ADDN   = 4'h9,
        OP_JUMPN  = 4'hA,
        OP_JUMPR  = 4'hB,
        OP_CALLN  = 4'hC,
        OP_JEQZN  = 4'hD,
        OP_JNEZN  = 4'hE,
        OP_JLTZN  = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    // Fields are pulled from a zero-extended 64-bit word so the
    // helpers work for any RW/DATA_W; callers cast to width.
    function automatic logic [63:0] fld_mask(input int w);
        return ~(64'hFFFF_FFFF_FFFF_FFFF << w);
    endfunction

    function automatic logic [63:0] fld_rd(input logic [63:0] i,
                                           input int rw);
        return (i >> 4) & fld_mask(rw);
    endfunction

    function automatic logic [63:0] fld_ra(input logic [63:0] i,
                                           input int rw);
        return (i >> (4 + rw)) & fld_mask(rw);
    endfunction

    function automatic logic [63:0] fld_rb(input logic [63:0] i,
                                           input int rw);
        return (i >> (4 + 2 * rw)) & fld_mask(rw);
    endfunction

    function automatic logic [63:0] fld_imm(input logic [63:0] i,
                                            input int rw,
                                            input int dw);
        return (i >> (4 + 3 * rw)) & fld_mask(dw);
    endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// HMMM register file: two async read ports, one sync write port.
// r0 always reads zero and ignores writes.
module hmmm_regfile
    import hmmm_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int DATA_W = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREGS];

    // Clear on reset; writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/hmmm_mc_core.sv
// HMMM multicycle core: FETCH/EXEC/MEM/HALT over a unified memory
// with a req/ready handshake tolerating wait states.
module hmmm_mc_core
    import hmmm_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    localparam int RW     = $clog2(NREGS),
    localparam int INSTR_W = 4 + 3 * RW + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic               halted,
    output logic               retire
);

    state_t             state;
    logic [DATA_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;

    op_t               op;
    logic [RW-1:0]     rd, ra, rb;
    logic [DATA_W-1:0] imm, ra_v, rb_v, pc1, npc;
    logic [DATA_W-1:0] ex_wd, rf_wd, maddr;
    logic              ex_we, rf_we;
    logic              is_mem, is_store, is_load;

    assign op  = op_t'(ir[3:0]);
    assign rd  = RW'(fld_rd(64'(ir), RW));
    assign ra  = RW'(fld_ra(64'(ir), RW));
    assign rb  = RW'(fld_rb(64'(ir), RW));
    assign imm = DATA_W'(fld_imm(64'(ir), RW, DATA_W));
    assign pc1 = pc + 1'b1;

    assign is_load  = (op == OP_LOADN) || (op == OP_LOADR);
    assign is_store = (op == OP_STOREN) || (op == OP_STORER);
    assign is_mem   = is_load || is_store;
    assign maddr    = (op == OP_LOADN || op == OP_STOREN) ? imm : rb_v;

    hmmm_regfile #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wd),
        .raddr_a (ra),
        .rdata_a (ra_v),
        .raddr_b (rb),
        .rdata_b (rb_v)
    );

    // Execute-stage result and next PC for non-memory ops
    always_comb begin
        npc   = pc1;
        ex_we = 1'b0;
        ex_wd = '0;
        unique case (op)
            OP_SETN:  begin ex_we = 1'b1; ex_wd = imm;         end
            OP_ADD:   begin ex_we = 1'b1; ex_wd = ra_v + rb_v; end
            OP_SUB:   begin ex_we = 1'b1; ex_wd = ra_v - rb_v; end
            OP_ADDN:  begin ex_we = 1'b1; ex_wd = ra_v + imm;  end
            OP_CALLN: begin ex_we = 1'b1; ex_wd = pc1; npc = imm; end
            OP_JUMPN: npc = imm;
            OP_JUMPR: npc = ra_v;
            OP_JEQZN: if (ra_v == '0) npc = imm;
            OP_JNEZN: if (ra_v != '0) npc = imm;
            OP_JLTZN: if (ra_v[DATA_W-1]) npc = imm;
            default:  ;
        endcase
    end

    // Register write: EXEC result or completed load
    always_comb begin
        rf_we = 1'b0;
        rf_wd = ex_wd;
        if (!reset) begin
            if (state == S_EXEC) begin
                rf_we = ex_we;
            end else if (state == S_MEM && mem_ready && is_load) begin
                rf_we = 1'b1;
                rf_wd = mem_rdata[DATA_W-1:0];
            end
        end
    end

    // Control FSM: sequence fetch, execute and memory phases
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            unique case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_HALT) begin
                        state <= S_HALT;
                    end else if (is_mem) begin
                        state <= S_MEM;
                    end else begin
                        pc    <= npc;
                        state <= S_FETCH;
                    end
                end
                S_MEM: if (mem_ready) begin
                    pc    <= pc1;
                    state <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Bus and status outputs; all quiet while reset is high
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        halted    = 1'b0;
        retire    = 1'b0;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                S_EXEC: retire = !is_mem;
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = is_store;
                    mem_addr  = maddr;
                    mem_wdata = is_store ? ra_v : '0;
                    retire    = mem_ready;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hmmm_mc_core.sv
// Scoreboard bench for hmmm_mc_core with a wait-state memory model.
// Expected bus transfers are queued by stimulus and popped by a monitor.
module tb_hmmm_mc_core;

    localparam int DW = 8;
    localparam int IW = 21;

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } xfer_t;

    logic          clk = 0;
    logic          reset = 1;
    logic          mem_req, mem_we, mem_ready, halted, retire;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic [IW-1:0] mem_rdata;

    logic [IW-1:0] mem [256];
    xfer_t         sb[$];

    int            checks = 0;
    int            failures = 0;
    logic          stall_en = 0;
    logic [DW-1:0] stall_addr = '0;
    int            stall_n = 0;
    int            wcnt = 0;

    hmmm_mc_core dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .retire    (retire)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = !(stall_en && mem_req && mem_addr == stall_addr
                         && wcnt < stall_n);

    always @(posedge clk) begin
        if (!mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // Monitor: every completed transfer must match the queue head
    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected: got we=%0b addr=%h wdata=%h required none",
                         mem_we, mem_addr, mem_wdata);
            end else begin
                xfer_t e;
                e = sb.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr ||
                    (e.we && mem_wdata !== e.wdata)) begin
                    failures++;
                    $display("FAIL xfer: got we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                end
            end
        end
    end

    function automatic logic [IW-1:0] enc(input int op, input int rd,
                                          input int ra, input int rb,
                                          input int imm);
        return {imm[7:0], rb[2:0], ra[2:0], rd[2:0], op[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic f(input int a);
        xfer_t x;
        x.we = 0; x.addr = DW'(a); x.wdata = '0;
        sb.push_back(x);
    endtask

    task automatic w(input int a, input int d);
        xfer_t x;
        x.we = 1; x.addr = DW'(a); x.wdata = DW'(d);
        sb.push_back(x);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("reset_outputs", {29'd0, mem_req, halted, retire}, 32'd0);
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halted"}, {31'd0, halted}, 32'd1);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        int cyc, rets, bad;

        // P1: SETN/ADDN/STOREN latency and store data
        clear_mem();
        mem[0] = enc(2, 1, 0, 0, 200);
        mem[1] = enc(9, 1, 1, 0, 100);
        mem[2] = enc(4, 0, 1, 0, 8'h80);
        mem[3] = enc(1, 0, 0, 0, 0);
        f(0); f(1); f(2); w(8'h80, 44); f(3);
        do_reset();
        cyc = 0; rets = 0;
        while (rets < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (retire) rets++;
        end
        chk("p1_cycles_to_3_retires", cyc, 7);
        run_to_halt("p1");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!halted || mem_req || retire) bad++;
        end
        chk("halt_hold_20", bad, 0);

        // P2: fetch of pc=2 stalled for three cycles
        clear_mem();
        mem[2] = enc(2, 2, 0, 0, 9);
        mem[3] = enc(4, 0, 2, 0, 8'h90);
        mem[4] = enc(1, 0, 0, 0, 0);
        f(0); f(1); f(2); f(3); w(8'h90, 9); f(4);
        stall_en = 1; stall_addr = 8'd2; stall_n = 3;
        do_reset();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold",
                {31'd0, mem_req && mem_addr == 8'd2 && !mem_ready && !retire},
                32'd1);
        end
        @(negedge clk);
        chk("stall_release", {31'd0, mem_ready && !retire}, 32'd1);
        @(negedge clk);
        chk("exec_after_ready", {31'd0, retire}, 32'd1);
        stall_en = 0;
        run_to_halt("p2");

        // P3: branches, call/return, r0, same-register cases
        clear_mem();
        mem[8'h00] = enc(2, 3, 0, 0, 8'h80);
        mem[8'h01] = enc(15, 0, 3, 0, 8'h20);
        mem[8'h20] = enc(2, 3, 0, 0, 0);
        mem[8'h21] = enc(15, 0, 3, 0, 8'h40);
        mem[8'h22] = enc(10, 0, 0, 0, 5);
        mem[8'h05] = enc(12, 4, 0, 0, 8'h10);
        mem[8'h10] = enc(11, 0, 4, 0, 0);
        mem[8'h06] = enc(2, 0, 0, 0, 7);
        mem[8'h07] = enc(4, 0, 0, 0, 8'h40);
        mem[8'h08] = enc(4, 0, 4, 0, 8'h41);
        mem[8'h09] = enc(13, 0, 0, 0, 8'h50);
        mem[8'h50] = enc(2, 1, 0, 0, 3);
        mem[8'h51] = enc(7, 1, 1, 1, 0);
        mem[8'h52] = enc(8, 2, 0, 1, 0);
        mem[8'h53] = enc(4, 0, 2, 0, 8'h42);
        mem[8'h54] = enc(2, 2, 0, 0, 8'h60);
        mem[8'h55] = enc(5, 2, 0, 2, 0);
        mem[8'h56] = enc(4, 0, 2, 0, 8'h43);
        mem[8'h57] = enc(6, 0, 1, 4, 0);
        mem[8'h58] = enc(14, 0, 1, 0, 8'h5A);
        mem[8'h5A] = enc(1, 0, 0, 0, 0);
        mem[8'h60] = 21'h1FF0A5;
        f(8'h00); f(8'h01); f(8'h20); f(8'h21); f(8'h22);
        f(8'h05); f(8'h10); f(8'h06); f(8'h07); w(8'h40, 0);
        f(8'h08); w(8'h41, 6); f(8'h09); f(8'h50); f(8'h51);
        f(8'h52); f(8'h53); w(8'h42, 250); f(8'h54); f(8'h55);
        f(8'h60); f(8'h56); w(8'h43, 8'hA5); f(8'h57); w(8'h06, 6);
        f(8'h58); f(8'h5A);
        do_reset();
        run_to_halt("p3");

        // P4: PC wraps from 0xFF to 0
        clear_mem();
        mem[8'h00] = enc(13, 0, 1, 0, 8'hFF);
        mem[8'hFF] = enc(2, 1, 0, 0, 1);
        mem[8'h01] = enc(1, 0, 0, 0, 0);
        f(8'h00); f(8'hFF); f(8'h00); f(8'h01);
        do_reset();
        run_to_halt("p4");

        // P5: reset during a stalled load abandons it
        clear_mem();
        mem[0] = enc(3, 1, 0, 0, 8'h70);
        mem[1] = enc(4, 0, 1, 0, 8'h71);
        mem[2] = enc(1, 0, 0, 0, 0);
        mem[8'h70] = 21'h1FF05C;
        f(0);
        stall_en = 1; stall_addr = 8'h70; stall_n = 1000;
        do_reset();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mem_req && mem_addr == 8'h70) && cyc < 20);
        chk("p5_in_mem", {31'd0, mem_req && !mem_we && !mem_ready}, 32'd1);
        reset = 1;
        #1;
        chk("p5_req_drop", {30'd0, mem_req, retire}, 32'd0);
        chk("p5_sb_after_abort", sb.size(), 32'd0);
        stall_en = 0;
        f(0); f(8'h70); f(1); w(8'h71, 8'h5C); f(2);
        @(posedge clk); @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("p5_first_fetch", {23'd0, halted, mem_addr},
            {23'd0, 1'b0, 8'h00});
        run_to_halt("p5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
